four_bit_1x2_demux: RTL
=======================

Name: four_bit_1x2_demux

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the adder/subtractor datapath's 4-bit 2x1 mux.
- Accepts one WIDTH-bit word per handshake on a valid/ready input and routes it, per Select, to output channel 1 or channel 0.
- Each channel has its own one-entry output buffer, so a stalled channel never blocks traffic to the other.
- Used to steer operand/result words between the adder and subtractor paths.

Parameters:
- WIDTH, 4, data word width.
- CNT_WIDTH, 8, width of per-channel transfer counters (used only with DEMUX_COUNT_EN).

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  synchronous, active-low reset.
- In  input  WIDTH  input data word.
- Select  input  1  destination: 1 routes to Out_1, 0 routes to Out_0; sampled only on an input handshake.
- In_Valid  input  1  In/Select valid.
- In_Ready  output  1  block can accept In this cycle.
- Out_1  output  WIDTH  channel 1 data.
- Out_1_Valid  output  1  channel 1 holds a word.
- Out_1_Ready  input  1  channel 1 consumer accepts.
- Out_0  output  WIDTH  channel 0 data.
- Out_0_Valid  output  1  channel 0 holds a word.
- Out_0_Ready  input  1  channel 0 consumer accepts.

Behaviour:
- One clock domain. Reset is synchronous and active-low: sampled on the rising edge of Clock while Reset_n=0.
- Reset values: Out_1=0, Out_0=0, Out_1_Valid=0, Out_0_Valid=0. In_Ready=0 while Reset_n=0.
- Per-channel state machine, states CH_EMPTY and CH_FULL:
  - Out_k_Valid = (state==CH_FULL).
  - Pop: Out_k_Valid and Out_k_Ready.
  - Load: In_Valid and In_Ready and Select==k.
  - CH_EMPTY + load -> CH_FULL, data captured.
  - CH_FULL + pop, no load -> CH_EMPTY, Out_k holds its last value.
  - CH_FULL + pop + load (same cycle) -> stays CH_FULL, new word replaces old; no bubble, no loss.
  - CH_FULL, no pop -> load impossible, because In_Ready=0 when Select==k.
- In_Ready = Reset_n and (target channel empty, or target channel popping this cycle). Target channel is the one named by the current Select.
  - This is a combinational path from Select and Out_k_Ready.
  - In_Ready does not depend on In_Valid.
- Latency: a word accepted at edge N appears on Out_k with Out_k_Valid=1 after edge N. Sustained throughput is one word per cycle per channel.
- Stability: while Out_k_Valid=1 and Out_k_Ready=0, Out_k and Out_k_Valid hold constant.
- Non-target channel: never modified by a load; it may pop independently in the same cycle.
- Data is passed through unmodified: no arithmetic, zero-extension or truncation, so all 2^WIDTH values are preserved.
- Reset mid-operation: buffered words are discarded, both channels go to CH_EMPTY, and counters clear. A handshake coincident with a reset edge is dropped.
- In_Valid=0: Select and In are don't-care and no state changes.

Optional Feature:
- Macro DEMUX_COUNT_EN.
- Defined:
  - Adds ports Count_1 and Count_0, each output, CNT_WIDTH bits.
  - Each counts pops on its channel, resets to 0, and wraps from 2^CNT_WIDTH-1 to 0.
  - Counting is pops only; loads are not counted.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package four_bit_demux_pkg:
  - ch_state_t enum {CH_EMPTY, CH_FULL}.
  - Constants DEFAULT_WIDTH=4 and DEFAULT_CNT_WIDTH=8.
  - Localparam SEL_CH1=1'b1, SEL_CH0=1'b0.
- Sub-module demux_channel_buffer: one-entry buffer holding state, data register, pop/load logic and the optional counter. Instantiated twice.
- The top level holds the Select decode and In_Ready.

Test Plan:
- Reset: Reset_n=0 for 2 cycles with In_Valid=1 -> In_Ready=0, both Valid=0, Out_1=Out_0=0; after release In_Ready=1.
- Exhaustive routing: Select=0, In swept 0x0..0xF with Out_0_Ready=1 -> Out_0 equals each value one cycle later, Out_1_Valid stays 0. Repeat with Select=1 on Out_1.
- Backpressure isolation: load 0xA to channel 1 with Out_1_Ready=0 -> Out_1=0xA held. Then Select=1 -> In_Ready=0. Then Select=0, In=0x5 -> accepted, Out_0=0x5 while Out_1 stays 0xA.
- Simultaneous pop+load: channel 0 full with 0x3, Out_0_Ready=1, In=0xC, Select=0 -> In_Ready=1; next cycle Out_0=0xC, Out_0_Valid=1.
- Reset mid-operation: both channels full (0x7, 0x9), Reset_n=0 for one edge -> both Valid=0, data=0; any concurrent input word is lost.
- DEMUX_COUNT_EN, CNT_WIDTH=8: 257 pops on channel 0 -> Count_0=1 (wrapped), Count_1=0.

Source files
------------

// File: rtl/four_bit_1x2_demux_pkg.sv
// Shared types and constants for the registered 1-to-2 demultiplexer.
package four_bit_demux_pkg;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_CNT_WIDTH = 8;

  localparam logic SEL_CH1 = 1'b1;
  localparam logic SEL_CH0 = 1'b0;

endpackage

// File: rtl/four_bit_1x2_demux_if.sv
// Handshake bundle for the demux: one valid/ready input, two valid/ready outputs.
// Count_1/Count_0 exist only when DEMUX_COUNT_EN is defined.
interface four_bit_1x2_demux_if
  import four_bit_demux_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);

  logic [WIDTH-1:0] In;
  logic             Select;
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] Out_1;
  logic             Out_1_Valid;
  logic             Out_1_Ready;
  logic [WIDTH-1:0] Out_0;
  logic             Out_0_Valid;
  logic             Out_0_Ready;
`ifdef DEMUX_COUNT_EN
  logic [CNT_WIDTH-1:0] Count_1;
  logic [CNT_WIDTH-1:0] Count_0;
`endif

  modport slave (
    input  In, Select, In_Valid, Out_1_Ready, Out_0_Ready,
    output In_Ready, Out_1, Out_1_Valid, Out_0, Out_0_Valid
`ifdef DEMUX_COUNT_EN
    , output Count_1, Count_0
`endif
  );

  modport master (
    output In, Select, In_Valid, Out_1_Ready, Out_0_Ready,
    input  In_Ready, Out_1, Out_1_Valid, Out_0, Out_0_Valid
`ifdef DEMUX_COUNT_EN
    , input Count_1, Count_0
`endif
  );

endinterface

// File: rtl/four_bit_1x2_demux_buffer.sv
// One-entry output buffer for a single demux channel (state, data, optional pop
// counter enabled by DEMUX_COUNT_EN). Accepts a load in the same cycle it pops.
module demux_channel_buffer
  import four_bit_demux_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             can_load,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
`ifdef DEMUX_COUNT_EN
  , output logic [CNT_WIDTH-1:0] count
`endif
);

  ch_state_t state;
  logic      pop;

  assign out_valid = (state == CH_FULL);
  assign pop       = out_valid && out_ready;
  // A full buffer can take a new word only in the cycle its current word leaves.
  assign can_load  = (state == CH_EMPTY) || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the data register is reset too because it is a
  // visible output with a defined reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CH_EMPTY;
      out_data <= '0;
    end else if (load) begin
      state    <= CH_FULL;
      out_data <= data_in;
    end else if (pop) begin
      state    <= CH_EMPTY;
    end
  end

`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)   count <= '0;
    else if (pop) count <= count + 1'b1;
  end
`endif

endmodule

// File: rtl/four_bit_1x2_demux.sv
// Registered 1-to-2 demultiplexer: routes each accepted word to channel 1 or 0
// by Select. Optional per-channel pop counters via DEMUX_COUNT_EN.
module four_bit_1x2_demux
  import four_bit_demux_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input logic                Clock,
  input logic                Reset_n,
  four_bit_1x2_demux_if.slave bus
);

  logic can_load_1, can_load_0;
  logic in_ready, accept;
  logic load_1, load_0;

  // Ready looks only at the channel Select currently names, never at In_Valid.
  assign in_ready    = Reset_n && ((bus.Select == SEL_CH1) ? can_load_1 : can_load_0);
  assign bus.In_Ready = in_ready;
  assign accept      = bus.In_Valid && in_ready;
  assign load_1      = accept && (bus.Select == SEL_CH1);
  assign load_0      = accept && (bus.Select == SEL_CH0);

  demux_channel_buffer #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ch1 (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .load      (load_1),
    .data_in   (bus.In),
    .out_ready (bus.Out_1_Ready),
    .can_load  (can_load_1),
    .out_data  (bus.Out_1),
    .out_valid (bus.Out_1_Valid)
`ifdef DEMUX_COUNT_EN
    , .count   (bus.Count_1)
`endif
  );

  demux_channel_buffer #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ch0 (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .load      (load_0),
    .data_in   (bus.In),
    .out_ready (bus.Out_0_Ready),
    .can_load  (can_load_0),
    .out_data  (bus.Out_0),
    .out_valid (bus.Out_0_Valid)
`ifdef DEMUX_COUNT_EN
    , .count   (bus.Count_0)
`endif
  );

endmodule
